// File: rtl/axis_meta_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_meta_fifo : AXIS meta FIFO, cut-through or store-and-forward packet mode
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_meta_fifo #(
    parameter int DATA_W   = 128,
    parameter int KEEP_W   = DATA_W / 8,
    parameter int TID_W    = 4,
    parameter int TDT_W    = 4,
    parameter int DEPTH    = 16,
    parameter int PKT_MODE = 0,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_meta_data,
    input  logic [KEEP_W-1:0] rx_meta_keep,
    input  logic              rx_meta_vld,
    input  logic [TID_W-1:0]  rx_meta_tid,
    input  logic [TDT_W-1:0]  rx_meta_tdt,
    input  logic              rx_meta_sop,
    input  logic              rx_meta_eop,
    output logic              rx_meta_rdy,
    output logic [DATA_W-1:0] tx_meta_data,
    output logic [KEEP_W-1:0] tx_meta_keep,
    output logic              tx_meta_vld,
    output logic [TID_W-1:0]  tx_meta_tid,
    output logic [TDT_W-1:0]  tx_meta_tdt,
    output logic              tx_meta_sop,
    output logic              tx_meta_eop,
    input  logic              tx_meta_rdy,
    output logic [CNT_W-1:0]  fill_lvl,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              oversize_err
);
    localparam int               AW       = $clog2(DEPTH);
    localparam int               WORD_W   = DATA_W + KEEP_W + TID_W + TDT_W + 2;
    localparam logic             PKT_EN   = (PKT_MODE != 0);
    localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              running;
    logic              force_rel;
    logic              push;
    logic              pop;
    logic              push_eop;
    logic              pop_eop;

    // The extra wrap bit makes the pointer difference the exact fill count.
    assign fill_lvl    = CNT_W'(wr_ptr - rd_ptr);
    assign rx_meta_rdy = running && (fill_lvl != CNT_FULL);
    assign tx_meta_vld = (fill_lvl != '0) && (!PKT_EN || (pkt_cnt != '0) || force_rel);

    assign push     = rx_meta_vld && rx_meta_rdy;
    assign pop      = tx_meta_vld && tx_meta_rdy;
    assign push_eop = push && rx_meta_eop;
    assign pop_eop  = pop && tx_meta_eop;

    assign {tx_meta_data, tx_meta_keep, tx_meta_tid, tx_meta_tdt,
            tx_meta_sop, tx_meta_eop} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {rx_meta_data, rx_meta_keep, rx_meta_tid,
                                    rx_meta_tdt, rx_meta_sop, rx_meta_eop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pkt_cnt      <= '0;
            force_rel    <= 1'b0;
            oversize_err <= 1'b0;
        end else begin
            running <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_eop && !pop_eop) begin
                pkt_cnt <= pkt_cnt + CNT_ONE;
            end else if (!push_eop && pop_eop) begin
                pkt_cnt <= pkt_cnt - CNT_ONE;
            end
            // A full FIFO holding no eop can never release: fall back to cut-through.
            if (pop_eop) begin
                force_rel <= 1'b0;
            end else if (PKT_EN && (fill_lvl == CNT_FULL) && (pkt_cnt == '0)) begin
                force_rel    <= 1'b1;
                oversize_err <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axis_meta_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axis_meta_fifo : cut-through and packet-mode instances against a queue model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_axis_meta_fifo;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic [3:0]   tid;
        logic [3:0]   tdt;
        logic         sop;
        logic         eop;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    beat_t        rx_beat [2];
    logic         rx_vld  [2];
    logic         tx_rdy  [2];
    logic         rx_rdy  [2];
    logic         tx_vld  [2];
    logic [127:0] tx_d    [2];
    logic [15:0]  tx_k    [2];
    logic [3:0]   tx_tid  [2];
    logic [3:0]   tx_tdt  [2];
    logic         tx_sop  [2];
    logic         tx_eop  [2];
    logic [4:0]   fill    [2];
    logic [4:0]   pkts    [2];
    logic         ovs     [2];

    // Instance 0 is cut-through, instance 1 is store-and-forward.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        axis_meta_fifo #(.DEPTH(DEPTH), .PKT_MODE(g)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .rx_meta_data (rx_beat[g].d),
            .rx_meta_keep (rx_beat[g].k),
            .rx_meta_vld  (rx_vld[g]),
            .rx_meta_tid  (rx_beat[g].tid),
            .rx_meta_tdt  (rx_beat[g].tdt),
            .rx_meta_sop  (rx_beat[g].sop),
            .rx_meta_eop  (rx_beat[g].eop),
            .rx_meta_rdy  (rx_rdy[g]),
            .tx_meta_data (tx_d[g]),
            .tx_meta_keep (tx_k[g]),
            .tx_meta_vld  (tx_vld[g]),
            .tx_meta_tid  (tx_tid[g]),
            .tx_meta_tdt  (tx_tdt[g]),
            .tx_meta_sop  (tx_sop[g]),
            .tx_meta_eop  (tx_eop[g]),
            .tx_meta_rdy  (tx_rdy[g]),
            .fill_lvl     (fill[g]),
            .pkt_cnt      (pkts[g]),
            .oversize_err (ovs[g])
        );
    end

    // Reference model: accepted beats in arrival order, indexed by push/pop totals.
    beat_t sb [2][256];
    int    wn   [2];
    int    rn   [2];
    int    eops [2];
    bit    frc  [2];
    bit    ovm  [2];
    bit    up   [2];

    int total = 0;
    int bad   = 0;

    function automatic bit m_vld(int d);
        return ((wn[d] - rn[d]) != 0) && (d == 0 || eops[d] != 0 || frc[d]);
    endfunction

    function automatic bit m_rdy(int d);
        return up[d] && ((wn[d] - rn[d]) != DEPTH);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                wn[d] = 0; rn[d] = 0; eops[d] = 0; frc[d] = 0; ovm[d] = 0; up[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                automatic bit    psh = rx_vld[d] && m_rdy(d);
                automatic bit    pp  = tx_rdy[d] && m_vld(d);
                automatic beat_t hb  = sb[d][rn[d] % 256];
                if (pp && hb.eop) begin
                    frc[d] = 0;
                end else if (d == 1 && (wn[d] - rn[d]) == DEPTH && eops[d] == 0) begin
                    frc[d] = 1;
                    ovm[d] = 1;
                end
                if (psh) begin
                    sb[d][wn[d] % 256] = rx_beat[d];
                    wn[d]++;
                    if (rx_beat[d].eop) eops[d]++;
                end
                if (pp) begin
                    rn[d]++;
                    if (hb.eop) eops[d]--;
                end
                up[d] = 1;
            end
        end
    end

    task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rx_rdy%0d", d), 160'(rx_rdy[d]), 160'(m_rdy(d)));
            chk($sformatf("tx_vld%0d", d), 160'(tx_vld[d]), 160'(m_vld(d)));
            chk($sformatf("fill%0d", d), 160'(fill[d]), 160'(wn[d] - rn[d]));
            chk($sformatf("pkt_cnt%0d", d), 160'(pkts[d]), 160'(eops[d]));
            chk($sformatf("oversize%0d", d), 160'(ovs[d]), 160'(ovm[d]));
            if (m_vld(d)) begin
                chk($sformatf("payload%0d", d),
                    160'({tx_d[d], tx_k[d], tx_tid[d], tx_tdt[d], tx_sop[d], tx_eop[d]}),
                    160'(sb[d][rn[d] % 256]));
            end
        end
    end

    function automatic beat_t mk(bit s, bit e);
        beat_t b;
        b.d   = {$urandom, $urandom, $urandom, $urandom};
        b.k   = 16'($urandom);
        b.tid = 4'($urandom);
        b.tdt = 4'($urandom);
        b.sop = s;
        b.eop = e;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int d, beat_t b);
        int n   = 0;
        bit acc = 0;
        rx_beat[d] = b;
        rx_vld[d]  = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = rx_rdy[d];
            tick();
            n++;
        end
        rx_vld[d] = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout dut%0d: accepted=0 expected 1", d);
        end
    endtask

    task automatic send_pkt(int d, int len, bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) tick();
            end
            send(d, mk(i == 0, i == len - 1));
        end
    endtask

    task automatic wait_empty(int d);
        int n = 0;
        while (fill[d] != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk($sformatf("drain%0d", d), 160'(fill[d]), 160'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    bit done;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rx_vld[d]  = 1'b0;
            tx_rdy[d]  = 1'b0;
            rx_beat[d] = '0;
        end
        repeat (3) tick();
        chk("reset_rdy", 160'(rx_rdy[0]), 160'(0));
        chk("reset_vld", 160'(tx_vld[0]), 160'(0));
        rst_n = 1'b1;
        tick();
        chk("post_reset_rdy", 160'(rx_rdy[1]), 160'(1));

        // Cut-through streaming with the sink always ready.
        tx_rdy[0] = 1'b1;
        for (int i = 0; i < 40; i++) send(0, mk(i == 0, i == 39));
        chk("stream_fill", 160'(fill[0]), 160'(1));
        wait_empty(0);

        // Fill to full with the sink stalled, then offer one more beat.
        tx_rdy[0] = 1'b0;
        send_pkt(0, 16, 0);
        rx_beat[0] = mk(1, 1);
        rx_vld[0]  = 1'b1;
        repeat (3) tick();
        rx_vld[0]  = 1'b0;
        chk("full_fill", 160'(fill[0]), 160'(16));
        chk("full_rdy", 160'(rx_rdy[0]), 160'(0));
        tx_rdy[0] = 1'b1;
        chk("full_rdy_pop_cycle", 160'(rx_rdy[0]), 160'(0));
        tick();
        chk("rdy_after_pop", 160'(rx_rdy[0]), 160'(1));
        wait_empty(0);

        // Store-and-forward: held until eop arrives.
        tx_rdy[1] = 1'b1;
        for (int i = 0; i < 4; i++) send(1, mk(i == 0, 0));
        chk("pkt_hold_vld", 160'(tx_vld[1]), 160'(0));
        send(1, mk(0, 1));
        chk("pkt_release_cnt", 160'(pkts[1]), 160'(1));
        chk("pkt_release_vld", 160'(tx_vld[1]), 160'(1));
        wait_empty(1);
        chk("pkt_cnt_zero", 160'(pkts[1]), 160'(0));

        // Oversize packet forces release, then the next packet is held again.
        send_pkt(1, 20, 0);
        chk("oversize_set", 160'(ovs[1]), 160'(1));
        wait_empty(1);
        send(1, mk(1, 0));
        send(1, mk(0, 0));
        chk("post_ovs_hold", 160'(tx_vld[1]), 160'(0));
        send(1, mk(0, 1));
        chk("post_ovs_release", 160'(tx_vld[1]), 160'(1));
        wait_empty(1);
        chk("oversize_sticky", 160'(ovs[1]), 160'(1));

        // Random traffic on both instances.
        done = 0;
        fork
            begin
                fork
                    for (int p = 0; p < 30; p++) send_pkt(0, $urandom_range(1, 8), 1);
                    for (int p = 0; p < 30; p++) send_pkt(1, $urandom_range(1, 8), 1);
                join
                done = 1;
            end
            for (int c = 0; c < 20000 && !done; c++) begin
                tick();
                tx_rdy[0] = 1'($urandom_range(0, 1));
                tx_rdy[1] = 1'($urandom_range(0, 1));
            end
        join
        tx_rdy[0] = 1'b1;
        tx_rdy[1] = 1'b1;
        wait_empty(0);
        wait_empty(1);

        // Reset in the middle of a packet.
        tx_rdy[0] = 1'b0;
        send_pkt(0, 9, 0);
        for (int i = 0; i < 9; i++) send(1, mk(i == 0, 0));
        chk("pre_reset_fill0", 160'(fill[0]), 160'(9));
        chk("pre_reset_fill1", 160'(fill[1]), 160'(9));
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_vld", 160'(tx_vld[0]), 160'(0));
        chk("reset_fill", 160'(fill[1]), 160'(0));
        chk("reset_ovs", 160'(ovs[1]), 160'(0));
        tick();
        rst_n = 1'b1;
        tick();
        tx_rdy[0] = 1'b1;
        send_pkt(0, 4, 0);
        send_pkt(1, 4, 0);
        wait_empty(0);
        wait_empty(1);
        chk("final_pkt_cnt", 160'(pkts[1]), 160'(0));
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
